ram_wb: RTL and testbench

RAM write-back stage of the cpu15 datapath. It sits directly upstream of the RAM read decoder and owns the eight 16-bit data RAM words RAM_0..RAM_7, which that decoder consumes. Store instructions write these words on CLK_WB. Address 64 is the memory-mapped output port IO64, delivered to the external consumer through a strobe/acknowledge handshake with a one-entry pending buffer.

---
 rtl/ram_wb.sv | 134 +++++++++++++
 tb/tb_ram_wb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ram_wb.sv
// cpu15 RAM write-back stage: eight data RAM words plus the IO64 output port handshake.
// Optional accepted-write counter on WR_CNT is enabled with `define RAM_WB_WCNT_EN.
module ram_wb #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned AD_W    = 8,
    parameter int unsigned IO64_AD = 64
) (
    input  logic              CLK_WB,
    input  logic              RESET_N,
    input  logic              RAM_WEN,
    input  logic [AD_W-1:0]   RAM_AD_IN,
    input  logic [DATA_W-1:0] RAM_IN,
    input  logic              IO64_ACK,
    output logic [DATA_W-1:0] RAM_0,
    output logic [DATA_W-1:0] RAM_1,
    output logic [DATA_W-1:0] RAM_2,
    output logic [DATA_W-1:0] RAM_3,
    output logic [DATA_W-1:0] RAM_4,
    output logic [DATA_W-1:0] RAM_5,
    output logic [DATA_W-1:0] RAM_6,
    output logic [DATA_W-1:0] RAM_7,
    output logic [DATA_W-1:0] IO64_OUT,
    output logic              IO64_STB,
    output logic              IO64_BUSY,
    output logic              IO64_OVF,
    output logic [7:0]        WR_CNT
);

    localparam int unsigned NUM_WORDS = 8;

    typedef enum logic [1:0] {IDLE, SHOW, FULL} state_t;

    state_t                              state_q, state_d;
    logic [NUM_WORDS-1:0][DATA_W-1:0]    ram_q;
    logic [DATA_W-1:0]                   out_q, out_d;
    logic [DATA_W-1:0]                   pend_q, pend_d;
    logic                                ovf_q, ovf_d;
    logic                                wr_ram, wr_io;

    assign wr_ram = RAM_WEN && (RAM_AD_IN < AD_W'(NUM_WORDS));
    assign wr_io  = RAM_WEN && (RAM_AD_IN == AD_W'(IO64_AD));

    // One register per word; only the addressed word loads.
    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
        always_ff @(posedge CLK_WB) begin
            if (!RESET_N)
                ram_q[i] <= '0;
            else if (wr_ram && RAM_AD_IN[2:0] == 3'(i))
                ram_q[i] <= RAM_IN;
        end
    end

    assign RAM_0 = ram_q[0];
    assign RAM_1 = ram_q[1];
    assign RAM_2 = ram_q[2];
    assign RAM_3 = ram_q[3];
    assign RAM_4 = ram_q[4];
    assign RAM_5 = ram_q[5];
    assign RAM_6 = ram_q[6];
    assign RAM_7 = ram_q[7];

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (wr_io) begin
                    out_d   = RAM_IN;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (IO64_ACK && wr_io) begin
                    out_d = RAM_IN;
                end else if (IO64_ACK) begin
                    state_d = IDLE;
                end else if (wr_io) begin
                    pend_d  = RAM_IN;
                    state_d = FULL;
                end
            end
            FULL: begin
                // Buffer drains on ACK; a store arriving while still full is lost.
                if (IO64_ACK) begin
                    out_d = pend_q;
                    if (wr_io)
                        pend_d = RAM_IN;
                    else
                        state_d = SHOW;
                end else if (wr_io) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_WB) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            out_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign IO64_OUT  = out_q;
    assign IO64_STB  = (state_q != IDLE);
    assign IO64_BUSY = (state_q == FULL);
    assign IO64_OVF  = ovf_q;

`ifdef RAM_WB_WCNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge CLK_WB) begin
        if (!RESET_N)
            cnt_q <= '0;
        else if ((wr_ram || wr_io) && cnt_q != 8'hFF)
            cnt_q <= cnt_q + 8'd1;
    end

    assign WR_CNT = cnt_q;
`else
    assign WR_CNT = '0;
`endif

endmodule

// File: tb/tb_ram_wb.sv
// Directed bench for ram_wb: RAM writes, ignored addresses, IO64 handshake, overflow, reset, counter.
module tb_ram_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen;
    logic [7:0]  ad;
    logic [15:0] din;
    logic        ack;
    logic [15:0] ram_obs [8];
    logic [15:0] io_out;
    logic        stb, busy, ovf;
    logic [7:0]  wr_cnt;

    logic [15:0] exp_ram [8];
    int          exp_cnt;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ram_wb dut (
        .CLK_WB   (clk),
        .RESET_N  (rst_n),
        .RAM_WEN  (wen),
        .RAM_AD_IN(ad),
        .RAM_IN   (din),
        .IO64_ACK (ack),
        .RAM_0    (ram_obs[0]),
        .RAM_1    (ram_obs[1]),
        .RAM_2    (ram_obs[2]),
        .RAM_3    (ram_obs[3]),
        .RAM_4    (ram_obs[4]),
        .RAM_5    (ram_obs[5]),
        .RAM_6    (ram_obs[6]),
        .RAM_7    (ram_obs[7]),
        .IO64_OUT (io_out),
        .IO64_STB (stb),
        .IO64_BUSY(busy),
        .IO64_OVF (ovf),
        .WR_CNT   (wr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_ram(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s ram%0d", tag, i), 32'(ram_obs[i]), 32'(exp_ram[i]));
    endtask

    // Inputs change #1 after the edge; outputs are read at the same point.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cnt_bump;
`ifdef RAM_WB_WCNT_EN
        if (exp_cnt < 255) exp_cnt++;
`endif
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic k);
        wen = 1'b1; ad = a; din = d; ack = k;
        step();
        wen = 1'b0; ack = 1'b0;
        if (a < 8) begin
            exp_ram[a[2:0]] = d;
            cnt_bump();
        end else if (a == 8'd64) begin
            cnt_bump();
        end
    endtask

    task automatic idle_cyc(input logic k);
        ack = k;
        step();
        ack = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) exp_ram[i] = 16'h0;
        exp_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0; wen = 1'b0; ad = '0; din = '0; ack = 1'b0;
        do_reset();
        chk_ram("reset");
        chk("reset out", 32'(io_out), 32'h0);
        chk("reset stb", 32'(stb), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset ovf", 32'(ovf), 32'h0);
        chk("reset cnt", 32'(wr_cnt), 32'h0);

        wr(8'd3, 16'h1234, 1'b0);
        chk_ram("wr3");
        chk("wr3 ram3", 32'(ram_obs[3]), 32'h1234);
        chk("wr3 stb", 32'(stb), 32'h0);
        chk("wr3 cnt", 32'(wr_cnt), 32'(exp_cnt));

        wr(8'd9, 16'hBEEF, 1'b0);
        wr(8'd65, 16'h5555, 1'b0);
        wr(8'd8, 16'hCAFE, 1'b0);
        chk_ram("ignored");
        chk("ignored out", 32'(io_out), 32'h0);
        chk("ignored stb", 32'(stb), 32'h0);
        chk("ignored cnt", 32'(wr_cnt), 32'(exp_cnt));

        wr(8'd64, 16'h00A1, 1'b0);
        chk("io show out", 32'(io_out), 32'h00A1);
        chk("io show stb", 32'(stb), 32'h1);
        chk("io show busy", 32'(busy), 32'h0);
        chk_ram("io no ram");
        idle_cyc(1'b1);
        chk("io ack stb", 32'(stb), 32'h0);
        chk("io ack out", 32'(io_out), 32'h00A1);
        idle_cyc(1'b1);
        chk("idle ack stb", 32'(stb), 32'h0);

        wr(8'd64, 16'h0001, 1'b0);
        wr(8'd64, 16'h0002, 1'b0);
        chk("full busy", 32'(busy), 32'h1);
        chk("full ovf0", 32'(ovf), 32'h0);
        wr(8'd64, 16'h0003, 1'b0);
        chk("ovf out", 32'(io_out), 32'h0001);
        chk("ovf busy", 32'(busy), 32'h1);
        chk("ovf flag", 32'(ovf), 32'h1);
        idle_cyc(1'b1);
        chk("drain out", 32'(io_out), 32'h0002);
        chk("drain busy", 32'(busy), 32'h0);
        chk("drain stb", 32'(stb), 32'h1);
        chk("drain ovf", 32'(ovf), 32'h1);

        wr(8'd64, 16'h0033, 1'b0);
        chk("refill busy", 32'(busy), 32'h1);
        chk("refill out", 32'(io_out), 32'h0002);
        wr(8'd64, 16'h0044, 1'b1);
        chk("full ackw out", 32'(io_out), 32'h0033);
        chk("full ackw busy", 32'(busy), 32'h1);
        idle_cyc(1'b1);
        chk("pend44 out", 32'(io_out), 32'h0044);
        chk("pend44 busy", 32'(busy), 32'h0);
        wr(8'd64, 16'h0055, 1'b1);
        chk("show ackw out", 32'(io_out), 32'h0055);
        chk("show ackw stb", 32'(stb), 32'h1);
        chk("show ackw busy", 32'(busy), 32'h0);
        wr(8'd64, 16'h0066, 1'b0);
        chk("pre rst busy", 32'(busy), 32'h1);
        chk("pre rst cnt", 32'(wr_cnt), 32'(exp_cnt));

        // reset with a write and ACK in flight must win
        rst_n = 1'b0; wen = 1'b1; ad = 8'd3; din = 16'hFFFF; ack = 1'b1;
        step();
        wen = 1'b0; ack = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 8; i++) exp_ram[i] = 16'h0;
        exp_cnt = 0;
        chk_ram("midrst");
        chk("midrst out", 32'(io_out), 32'h0);
        chk("midrst stb", 32'(stb), 32'h0);
        chk("midrst busy", 32'(busy), 32'h0);
        chk("midrst ovf", 32'(ovf), 32'h0);
        chk("midrst cnt", 32'(wr_cnt), 32'h0);
        idle_cyc(1'b1);
        chk("midrst idle", 32'(io_out), 32'h0);

        wr(8'd0, 16'hAAAA, 1'b0);
        wr(8'd7, 16'h7777, 1'b0);
        chk_ram("edges");

        for (int i = 0; i < 300; i++) wr(8'd0, 16'(i), 1'b0);
        chk_ram("sat");
        chk("sat cnt", 32'(wr_cnt), 32'(exp_cnt));
`ifdef RAM_WB_WCNT_EN
        chk("sat 255", 32'(wr_cnt), 32'd255);
`else
        chk("cnt off", 32'(wr_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
